capture_buffer: RTL and testbench

- Parametrised sample-capture buffer: WIDTH-bit samples written sequentially into a DEPTH-entry register array.
- Supports one-shot (stop when full) and ring (wrap/overwrite until stopped) modes, with a start/stop/done handshake.
- Registered read port uses logical addressing: address 0 is always the oldest captured sample.
- Sits behind counters and datapaths as a debug/trace store, replacing hand-written fixed 8x4 buffers.

---
 rtl/capture_buffer.sv | 102 ++++++++++
 tb/tb_capture_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
// Sample-capture buffer: one-shot or ring capture into a DEPTH-entry array, logical-order registered read.
// Optional decimation of the input stream is enabled by defining CAPTURE_BUFFER_DECIM_EN.
module capture_buffer #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
`ifdef CAPTURE_BUFFER_DECIM_EN
  input  logic [3:0]        decim,
`endif
  output logic              busy,
  output logic              done,
  output logic              wrapped,
  output logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  logic [1:0]        state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] oldest;
  logic [ADDR_W-1:0] phys;
  logic              mode_q;
  logic              accept;
  logic              take;
  logic              wr_en;

`ifdef CAPTURE_BUFFER_DECIM_EN
  logic [3:0] decim_q;
  logic [3:0] dcnt;
  assign take = (dcnt == 4'd0);
`else
  assign take = 1'b1;
`endif

  // start is only honoured outside CAPTURE; it always beats a coincident stop
  assign accept = start && (state != S_CAP);
  assign wr_en  = (state == S_CAP) && din_valid && take;

  // once the ring has overwritten, the oldest sample sits at the write pointer
  assign oldest = (count == FULL && wrapped) ? wr_ptr : '0;
  assign phys   = oldest + rd_addr;

  assign busy = (state == S_CAP);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      count   <= '0;
      wrapped <= 1'b0;
      mode_q  <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef CAPTURE_BUFFER_DECIM_EN
      decim_q <= 4'd0;
      dcnt    <= 4'd0;
`endif
    end else begin
      rd_data <= mem[phys];
      if (accept) begin
        state   <= S_CAP;
        mode_q  <= mode;
        wr_ptr  <= '0;
        count   <= '0;
        wrapped <= 1'b0;
`ifdef CAPTURE_BUFFER_DECIM_EN
        decim_q <= decim;
        dcnt    <= 4'd0;
`endif
      end else if (state == S_CAP) begin
        if (wr_en) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= wr_ptr + ADDR_W'(1);
          if (count == FULL) wrapped <= 1'b1;
          else               count   <= count + (ADDR_W+1)'(1);
        end
        if (stop || (wr_en && !mode_q && count == LAST)) state <= S_DONE;
`ifdef CAPTURE_BUFFER_DECIM_EN
        if (din_valid) dcnt <= (dcnt == decim_q) ? 4'd0 : dcnt + 4'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: stimulus queues expectations, a negedge monitor pops and compares.
module tb_capture_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0, din_valid = 1'b0;
  logic [3:0] din = '0;
  logic [2:0] rd_addr = '0;
  logic       busy, done, wrapped;
  logic [3:0] count;
  logic [3:0] rd_data;
`ifdef CAPTURE_BUFFER_DECIM_EN
  logic [3:0] decim = '0;
`endif

  capture_buffer #(.WIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .din(din), .din_valid(din_valid),
`ifdef CAPTURE_BUFFER_DECIM_EN
    .decim(decim),
`endif
    .busy(busy), .done(done), .wrapped(wrapped), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic b; logic d; logic w; logic [3:0] c; } st_t;
  typedef struct { string tag; logic [3:0] v; } rd_t;

  st_t st_q[$];
  rd_t rd_q[$];
  st_t se;
  rd_t re;
  int total = 0;
  int bad = 0;
  logic st_tag = 1'b0, rd_tag = 1'b0, rd_pend = 1'b0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  always @(posedge clk) rd_pend <= rd_tag;

  always @(negedge clk) begin
    if (st_tag) begin
      if (st_q.size() == 0) chk("status_queue_empty", 32'd1, 32'd0);
      else begin
        se = st_q.pop_front();
        chk({se.tag, ".busy"},    32'(busy),    32'(se.b));
        chk({se.tag, ".done"},    32'(done),    32'(se.d));
        chk({se.tag, ".wrapped"}, 32'(wrapped), 32'(se.w));
        chk({se.tag, ".count"},   32'(count),   32'(se.c));
      end
    end
    if (rd_pend) begin
      if (rd_q.size() == 0) chk("read_queue_empty", 32'd1, 32'd0);
      else begin
        re = rd_q.pop_front();
        chk(re.tag, 32'(rd_data), 32'(re.v));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic st(string tag, logic b, logic d, logic w, logic [3:0] c);
    st_t e;
    e.tag = tag; e.b = b; e.d = d; e.w = w; e.c = c;
    st_q.push_back(e);
    st_tag = 1'b1;
    @(negedge clk); #1;
    st_tag = 1'b0;
  endtask

  task automatic rd(string tag, logic [2:0] a, logic [3:0] v);
    rd_t e;
    e.tag = $sformatf("%s[%0d]", tag, a); e.v = v;
    rd_q.push_back(e);
    rd_addr = a;
    rd_tag  = 1'b1;
    tick();
    rd_tag  = 1'b0;
  endtask

  initial begin
    // reset
    tick(); tick();
    rst = 1'b0;
    st("reset", 0, 0, 0, 0);
    for (int a = 0; a < 8; a++) rd("reset_rd", 3'(a), 4'd0);

    // one-shot fill; start with coincident stop in IDLE
    mode = 1'b0; start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    st("os_armed", 1, 0, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      din = 4'(i); din_valid = 1'b1; tick();
      if (i == 7) st("os_7", 1, 0, 0, 7);
      if (i == 8) st("os_8", 0, 1, 0, 8);
    end
    din_valid = 1'b0;
    st("os_end", 0, 1, 0, 8);
    for (int a = 0; a < 8; a++) rd("os_rd", 3'(a), 4'(a + 1));

    // ring wrap
    mode = 1'b1; start = 1'b1; tick(); start = 1'b0;
    st("ring_armed", 1, 0, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      din = 4'(i); din_valid = 1'b1; tick();
      if (i == 8) st("ring_8", 1, 0, 0, 8);
      if (i == 9) st("ring_9", 1, 0, 1, 8);
    end
    din_valid = 1'b0; stop = 1'b1; tick(); stop = 1'b0;
    st("ring_end", 0, 1, 1, 8);
    for (int a = 0; a < 8; a++) rd("ring_rd", 3'(a), 4'(a + 4));

    // gaps and early stop coincident with last sample; array is now 9,10,11,4..8
    mode = 1'b0; start = 1'b1; tick(); start = 1'b0;
    din = 4'd5; din_valid = 1'b1; tick();
    din_valid = 1'b0; tick();
    din = 4'd6; din_valid = 1'b1; tick();
    din_valid = 1'b0; tick();
    din = 4'd7; din_valid = 1'b1; stop = 1'b1; tick();
    din_valid = 1'b0; stop = 1'b0;
    st("gap_end", 0, 1, 0, 3);
    rd("gap_rd", 3'd0, 4'd5);
    rd("gap_rd", 3'd1, 4'd6);
    rd("gap_rd", 3'd2, 4'd7);
    rd("gap_stale", 3'd3, 4'd4);
    stop = 1'b1; tick(); stop = 1'b0;
    st("stop_in_done", 0, 1, 0, 3);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    st("start_wins_done", 1, 0, 0, 0);

    // reset mid-capture
    for (int i = 12; i <= 14; i++) begin din = 4'(i); din_valid = 1'b1; tick(); end
    din_valid = 1'b0;
    st("pre_rst", 1, 0, 0, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    st("mid_rst", 0, 0, 0, 0);
    rd("rst_clr", 3'd0, 4'd0);
    rd("rst_clr", 3'd2, 4'd0);

    // restart handling: start in CAPTURE ignored, start from DONE keeps old data
    start = 1'b1; tick(); start = 1'b0;
    din = 4'd1; din_valid = 1'b1; tick();
    din = 4'd2; tick();
    din = 4'd3; start = 1'b1; tick(); start = 1'b0;
    din_valid = 1'b0;
    st("start_ignored", 1, 0, 0, 3);
    stop = 1'b1; tick(); stop = 1'b0;
    st("stopped", 0, 1, 0, 3);
    start = 1'b1; tick(); start = 1'b0;
    st("restart", 1, 0, 0, 0);
    din = 4'd9; din_valid = 1'b1;
    rd("rd_during_wr", 3'd0, 4'd1);
    din_valid = 1'b0;
    rd("restart_rd", 3'd0, 4'd9);
    rd("restart_rd", 3'd1, 4'd2);
    rd("restart_rd", 3'd2, 4'd3);
    st("restart_cnt", 1, 0, 0, 1);
    stop = 1'b1; tick(); stop = 1'b0;

`ifdef CAPTURE_BUFFER_DECIM_EN
    // decimation by 3, one-shot
    decim = 4'd2; mode = 1'b0; start = 1'b1; tick(); start = 1'b0; decim = 4'd0;
    for (int i = 1; i <= 24; i++) begin
      din = 4'(i); din_valid = 1'b1; tick();
      if (i == 21) st("dec_21", 1, 0, 0, 7);
      if (i == 22) st("dec_22", 0, 1, 0, 8);
    end
    din_valid = 1'b0;
    for (int a = 0; a < 8; a++) rd("dec_rd", 3'(a), 4'(1 + 3 * a));
`endif

    repeat (3) tick();
    chk("sb_drain", 32'(st_q.size() + rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
